// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V integer divide unit.
//   XLEN       : operand/result width (only 32 supported)
//   DIV_STEPS  : number of restoring-division iterations
//   div_op_e   : divide operation code, equal to funct3[1:0]
//   div_state_e: divider control FSM states
//   cond_neg   : conditional two's-complement negate helper
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] val,
                                               input logic            neg);
    if (neg) begin
      cond_neg = ~val + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      cond_neg = val;
    end
  endfunction

endpackage

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative 32-bit restoring divider for DIV/DIVU/REM/REMU.
// A start accepted in IDLE captures op, rd and operands. Divide-by-zero and
// signed overflow finish immediately; everything else iterates 32 cycles on
// operand magnitudes and fixes up signs at the end.
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-low reset
//   i_start     request a divide (only honoured in IDLE)
//   i_op        operation code (div_op_e)
//   i_rs1_data  dividend
//   i_rs2_data  divisor
//   i_rd_addr   destination register address
//   o_busy      high while an operation is in CALC or DONE
//   o_done      one-cycle result strobe
//   o_rd_addr   captured destination address
//   o_rd_data   result
//   o_rd_wren   register-file write enable (o_done with rd != 0)
// -----------------------------------------------------------------------------
module div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  output logic            o_busy,
  output logic            o_done,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_rd_wren
);

  div_state_e      state_r, state_s;
  logic [4:0]      cnt_r;
  div_op_e         op_r;
  logic [4:0]      rd_r;
  logic [XLEN-1:0] quo_r;     // dividend magnitude shifting out, quotient shifting in
  logic [XLEN-1:0] rem_r;     // partial remainder
  logic [XLEN-1:0] dvs_r;     // divisor magnitude
  logic            neg_q_r;
  logic            neg_r_r;

  div_op_e         op_in_s;
  logic            signed_in_s;
  logic            neg1_s;
  logic            neg2_s;
  logic            div0_s;
  logic            ovf_s;
  logic            special_s;
  logic            accept_s;

  logic [XLEN:0]   rem_shift_s;
  logic            q_bit_s;
  logic [XLEN-1:0] rem_step_s;
  logic [XLEN-1:0] quo_step_s;

  logic            is_rem_s;
  logic [XLEN-1:0] res_s;

  logic            busy_s;
  logic            done_s;
  logic            wren_s;
  logic [4:0]      addr_s;
  logic [XLEN-1:0] data_s;

  // Decode the incoming request: signedness, operand signs, special cases.
  always_comb begin
    op_in_s     = div_op_e'(i_op);
    signed_in_s = (op_in_s == OP_DIV) || (op_in_s == OP_REM);
    neg1_s      = signed_in_s & i_rs1_data[XLEN-1];
    neg2_s      = signed_in_s & i_rs2_data[XLEN-1];
    div0_s      = (i_rs2_data == {XLEN{1'b0}});
    ovf_s       = signed_in_s &&
                  (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (i_rs2_data == {XLEN{1'b1}});
    special_s   = div0_s || ovf_s;
    accept_s    = (state_r == ST_IDLE) && i_start;
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift_s = {rem_r, quo_r[XLEN-1]};
    if (rem_shift_s >= {1'b0, dvs_r}) begin
      q_bit_s    = 1'b1;
      rem_step_s = rem_shift_s[XLEN-1:0] - dvs_r;
    end else begin
      q_bit_s    = 1'b0;
      rem_step_s = rem_shift_s[XLEN-1:0];
    end
    quo_step_s = {quo_r[XLEN-2:0], q_bit_s};
  end

  // Final result: pick quotient or remainder and restore its sign.
  always_comb begin
    is_rem_s = (op_r == OP_REM) || (op_r == OP_REMU);
    if (is_rem_s) begin
      res_s = cond_neg(rem_r, neg_r_r);
    end else begin
      res_s = cond_neg(quo_r, neg_q_r);
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_s = special_s ? ST_DONE : ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == 5'd0) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered outputs.
  always_comb begin
    busy_s = (state_s != ST_IDLE);
    done_s = 1'b0;
    wren_s = 1'b0;
    addr_s = o_rd_addr;
    data_s = o_rd_data;
    case (state_r)
      ST_DONE: begin
        done_s = 1'b1;
        wren_s = (rd_r != 5'd0);
        addr_s = rd_r;
        data_s = res_s;
      end
      default: begin
        done_s = 1'b0;
        wren_s = 1'b0;
      end
    endcase
  end

  // Output registers; address and data hold between results.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_rd_wren <= 1'b0;
      o_rd_addr <= 5'd0;
      o_rd_data <= {XLEN{1'b0}};
    end else begin
      o_busy    <= busy_s;
      o_done    <= done_s;
      o_rd_wren <= wren_s;
      o_rd_addr <= addr_s;
      o_rd_data <= data_s;
    end
  end

  // Datapath: capture on accept (special cases preload their final answer), iterate in CALC.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_r   <= 5'd0;
      op_r    <= OP_DIV;
      rd_r    <= 5'd0;
      quo_r   <= {XLEN{1'b0}};
      rem_r   <= {XLEN{1'b0}};
      dvs_r   <= {XLEN{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (accept_s) begin
      op_r  <= op_in_s;
      rd_r  <= i_rd_addr;
      cnt_r <= 5'(DIV_STEPS - 1);
      dvs_r <= cond_neg(i_rs2_data, neg2_s);
      if (special_s) begin
        // Divide-by-zero: quotient all ones, remainder is the raw dividend.
        // Overflow: quotient is the most negative value, remainder zero.
        quo_r   <= div0_s ? {XLEN{1'b1}} : {1'b1, {(XLEN-1){1'b0}}};
        rem_r   <= div0_s ? i_rs1_data : {XLEN{1'b0}};
        neg_q_r <= 1'b0;
        neg_r_r <= 1'b0;
      end else begin
        quo_r   <= cond_neg(i_rs1_data, neg1_s);
        rem_r   <= {XLEN{1'b0}};
        neg_q_r <= neg1_s ^ neg2_s;
        neg_r_r <= neg1_s;
      end
    end else if (state_r == ST_CALC) begin
      quo_r <= quo_step_s;
      rem_r <= rem_step_s;
      cnt_r <= cnt_r - 5'd1;
    end else begin
      quo_r <= quo_r;
      rem_r <= rem_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Self-checking bench for div_unit: directed vectors with known answers,
// randomized operations against an arithmetic reference model, restart
// immunity, and reset abort.
// -----------------------------------------------------------------------------
module tb_div_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic        o_busy;
  logic        o_done;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  div_unit dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_rd_addr  (i_rd_addr),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_rd_addr  (o_rd_addr),
    .o_rd_data  (o_rd_data),
    .o_rd_wren  (o_rd_wren)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // RISC-V M-extension divide semantics using plain integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        if (b == 32'd0) ref_div = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ref_div = 32'h80000000;
        else ref_div = sa / sb;
      end
      2'b01: begin
        if (b == 32'd0) ref_div = 32'hFFFFFFFF;
        else ref_div = a / b;
      end
      2'b10: begin
        if (b == 32'd0) ref_div = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ref_div = 32'd0;
        else ref_div = sa % sb;
      end
      default: begin
        if (b == 32'd0) ref_div = a;
        else ref_div = a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 1;
    if ((op == 2'b00 || op == 2'b10) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Issue one operation from idle, scramble inputs after accept, collect what the DUT shows.
  task automatic issue_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output bit seen, output int lat,
                          output logic [31:0] data, output logic [4:0] addr, output logic wren,
                          output logic busy_acc, output logic busy_done,
                          output logic done_after, output logic [31:0] data_after);
    i_start    = 1'b1;
    i_op       = op;
    i_rs1_data = a;
    i_rs2_data = b;
    i_rd_addr  = rd;
    @(posedge i_clk); #1;
    busy_acc   = o_busy;
    i_start    = 1'b0;
    i_op       = 2'($urandom_range(3));
    i_rs1_data = $urandom;
    i_rs2_data = $urandom;
    i_rd_addr  = 5'($urandom_range(31));
    seen = 1'b0;
    lat  = 0;
    data = 32'd0;
    addr = 5'd0;
    wren = 1'b0;
    busy_done = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge i_clk); #1;
      lat++;
      if (o_done === 1'b1) begin
        seen      = 1'b1;
        data      = o_rd_data;
        addr      = o_rd_addr;
        wren      = o_rd_wren;
        busy_done = o_busy;
      end
    end
    @(posedge i_clk); #1;
    done_after = o_done;
    data_after = o_rd_data;
  endtask

  task automatic test_reset();
    i_rst      = 1'b0;
    i_start    = 1'b1;
    i_op       = 2'b00;
    i_rs1_data = 32'd100;
    i_rs2_data = 32'd7;
    i_rd_addr  = 5'd5;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if ({o_busy, o_done, o_rd_wren} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/wren=%b expected 000", {o_busy, o_done, o_rd_wren});
    end
    checks++;
    if (o_rd_addr !== 5'd0 || o_rd_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got addr=%0d data=%h expected 0/0", o_rd_addr, o_rd_data);
    end
    i_start = 1'b0;
    i_rst   = 1'b1;
    @(posedge i_clk); #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b expected 0", o_busy);
    end
  endtask

  task automatic test_directed();
    vec_t        v[13];
    bit          seen;
    int          lat;
    logic [31:0] data, data_after;
    logic [4:0]  addr;
    logic        wren, busy_acc, busy_done, done_after;
    v[0]  = '{2'b00, 32'd100,        32'd7,          5'd5,  32'd14,         33};
    v[1]  = '{2'b10, 32'hFFFFFFF9,   32'd2,          5'd3,  32'hFFFFFFFF,   33};
    v[2]  = '{2'b01, 32'hFFFFFFFF,   32'd2,          5'd31, 32'h7FFFFFFF,   33};
    v[3]  = '{2'b01, 32'd5,          32'd0,          5'd1,  32'hFFFFFFFF,   1};
    v[4]  = '{2'b11, 32'd5,          32'd0,          5'd2,  32'd5,          1};
    v[5]  = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   5'd4,  32'h80000000,   1};
    v[6]  = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   5'd6,  32'd0,          1};
    v[7]  = '{2'b00, 32'd9,          32'd3,          5'd0,  32'd3,          33};
    v[8]  = '{2'b00, 32'hFFFFFF9C,   32'd7,          5'd7,  32'hFFFFFFF2,   33};
    v[9]  = '{2'b10, 32'd100,        32'hFFFFFFF9,   5'd8,  32'd2,          33};
    v[10] = '{2'b10, 32'hFFFFFF9C,   32'd7,          5'd9,  32'hFFFFFFFE,   33};
    v[11] = '{2'b01, 32'h80000000,   32'h00000010,   5'd10, 32'h08000000,   33};
    v[12] = '{2'b10, 32'h80000000,   32'd0,          5'd11, 32'h80000000,   1};
    for (int i = 0; i < 13; i++) begin
      issue_op(v[i].op, v[i].a, v[i].b, v[i].rd, seen, lat, data, addr, wren,
               busy_acc, busy_done, done_after, data_after);
      checks++;
      if (busy_acc !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_busy: got busy=%b after accept expected 1", i, busy_acc);
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL dir%0d_timeout: got no o_done within 40 cycles expected one", i);
      end else begin
        checks++;
        if (lat !== v[i].lat) begin
          errors++;
          $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, v[i].lat);
        end
        checks++;
        if (data !== v[i].exp) begin
          errors++;
          $display("FAIL dir%0d_data: got %h expected %h", i, data, v[i].exp);
        end
        checks++;
        if (addr !== v[i].rd || wren !== (v[i].rd != 5'd0)) begin
          errors++;
          $display("FAIL dir%0d_wb: got addr=%0d wren=%b expected addr=%0d wren=%b",
                   i, addr, wren, v[i].rd, (v[i].rd != 5'd0));
        end
        checks++;
        if (busy_done !== 1'b0) begin
          errors++;
          $display("FAIL dir%0d_busy_done: got busy=%b with o_done expected 0", i, busy_done);
        end
      end
      checks++;
      if (done_after !== 1'b0 || data_after !== v[i].exp) begin
        errors++;
        $display("FAIL dir%0d_hold: got done=%b data=%h expected done=0 data=%h",
                 i, done_after, data_after, v[i].exp);
      end
    end
  endtask

  task automatic test_random();
    bit          seen;
    int          lat;
    int          mode;
    logic [1:0]  op;
    logic [31:0] a, b, exp, data, data_after;
    logic [4:0]  rd, addr;
    logic        wren, busy_acc, busy_done, done_after;
    for (int i = 0; i < 30; i++) begin
      op   = 2'($urandom_range(3));
      mode = int'($urandom_range(4));
      a    = $urandom;
      b    = $urandom;
      rd   = 5'($urandom_range(31));
      case (mode)
        1: b = ($urandom_range(1) == 1) ? 32'($urandom_range(1, 15)) : (32'd0 - 32'($urandom_range(1, 15)));
        2: b = 32'd0;
        3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        4: a = 32'($urandom_range(1000));
        default: a = a;
      endcase
      exp = ref_div(op, a, b);
      issue_op(op, a, b, rd, seen, lat, data, addr, wren,
               busy_acc, busy_done, done_after, data_after);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL rnd%0d_timeout: got no o_done expected one (op=%0d a=%h b=%h)", i, op, a, b);
      end else begin
        checks++;
        if (lat !== ref_latency(op, a, b)) begin
          errors++;
          $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, ref_latency(op, a, b));
        end
        checks++;
        if (data !== exp) begin
          errors++;
          $display("FAIL rnd%0d_data: got %h expected %h (op=%0d a=%h b=%h)", i, data, exp, op, a, b);
        end
        checks++;
        if (addr !== rd || wren !== (rd != 5'd0)) begin
          errors++;
          $display("FAIL rnd%0d_wb: got addr=%0d wren=%b expected addr=%0d wren=%b",
                   i, addr, wren, rd, (rd != 5'd0));
        end
      end
    end
  endtask

  // A start held high through mid-CALC and DONE must be ignored completely.
  task automatic test_restart_ignored();
    int          dones;
    int          done_cyc;
    logic [31:0] done_data;
    i_start    = 1'b1;
    i_op       = 2'b00;
    i_rs1_data = 32'd1000;
    i_rs2_data = 32'd7;
    i_rd_addr  = 5'd9;
    @(posedge i_clk); #1;
    i_start   = 1'b0;
    dones     = 0;
    done_cyc  = 0;
    done_data = 32'd0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge i_clk); #1;
      if (o_done === 1'b1) begin
        dones++;
        done_cyc  = k;
        done_data = o_rd_data;
      end
      if (k == 4) begin
        i_start    = 1'b1;
        i_op       = 2'b11;
        i_rs1_data = 32'd5;
        i_rs2_data = 32'd0;
        i_rd_addr  = 5'd12;
      end
      if (k == 33) i_start = 1'b0;
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL restart_count: got %0d o_done pulses expected 1", dones);
    end
    checks++;
    if (done_cyc !== 33 || done_data !== 32'd142) begin
      errors++;
      $display("FAIL restart_result: got cycle=%0d data=%h expected cycle=33 data=%h",
               done_cyc, done_data, 32'd142);
    end
  endtask

  // Reset 10 cycles into CALC aborts the operation without any write-back.
  task automatic test_reset_abort();
    int dones;
    i_start    = 1'b1;
    i_op       = 2'b00;
    i_rs1_data = 32'd100;
    i_rs2_data = 32'd7;
    i_rd_addr  = 5'd5;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_pre: got busy=%b expected 1", o_busy);
    end
    i_rst   = 1'b0;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    checks++;
    if (o_busy !== 1'b0 || o_rd_data !== 32'd0) begin
      errors++;
      $display("FAIL abort_cleared: got busy=%b data=%h expected 0/0", o_busy, o_rd_data);
    end
    i_rst   = 1'b1;
    i_start = 1'b0;
    dones   = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge i_clk); #1;
      if (o_done === 1'b1 || o_rd_wren === 1'b1 || o_busy === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles after reset expected 0", dones);
    end
  endtask

  initial begin
    i_rst      = 1'b0;
    i_start    = 1'b0;
    i_op       = 2'b00;
    i_rs1_data = 32'd0;
    i_rs2_data = 32'd0;
    i_rd_addr  = 5'd0;
    #1;
    test_reset();
    test_directed();
    test_random();
    test_restart_ignored();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: XLEN, 32, operand and result width; only 32 is supported.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset, synchronous and active-low.
REQ-004 i_start  input  1  request a divide operation; sampled only in IDLE.
REQ-005 i_op  input  2  operation code: 00 DIV, 01 DIVU, 10 REM, 11 REMU (equal to funct3[1:0]).
REQ-006 i_rs1_data  input  32  dividend.
REQ-007 i_rs2_data  input  32  divisor.
REQ-008 i_rd_addr  input  5  destination register address.
REQ-009 o_busy  output  1  high in CALC and DONE.
REQ-010 o_done  output  1  one-cycle result-valid strobe.
REQ-011 o_rd_addr  output  5  captured destination address; drives the register-file write address.
REQ-012 o_rd_data  output  32  result; drives the register-file write data.
REQ-013 o_rd_wren  output  1  register-file write enable; equals o_done AND (o_rd_addr != 0).

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-015 IDLE with i_start=1 SHALL capture i_op, i_rd_addr and both operands on that edge.
- A special case (REQ-019, REQ-020) goes to DONE.
- Otherwise the FSM goes to CALC with the step counter set to 31.
REQ-016 CALC SHALL run one restoring-division step per cycle on operand magnitudes, for exactly 32 cycles.
- The counter decrements each cycle.
- The FSM goes to DONE on the cycle the counter is 0.
REQ-017 DONE SHALL last exactly one cycle, with o_done=1 and o_rd_data valid, then return to IDLE.
REQ-018 Latency from the start-accept edge to o_done SHALL be 33 cycles normally and 1 cycle for special cases.
REQ-019 For a divisor of zero:
- DIV and DIVU SHALL return 0xFFFFFFFF.
- REM and REMU SHALL return the dividend.
REQ-020 For signed overflow (0x80000000 / 0xFFFFFFFF), DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-021 Sign rules for signed ops:
- Magnitudes are taken before iterating.
- The quotient is negated when the operand signs differ.
- The remainder takes the sign of the dividend.
REQ-022 Unsigned ops SHALL use the operands unmodified.
REQ-023 i_start in CALC or DONE SHALL be ignored, with no capture and no queuing.
REQ-024 The captured operands, op and rd SHALL be immune to input changes after the accept edge.
REQ-025 With rd=0, the unit SHALL still strobe o_done, but o_rd_wren SHALL stay 0.
REQ-026 The output registers SHALL hold their value outside DONE; only o_done and o_rd_wren are qualified.

Reset
REQ-027 When i_rst=0 at a rising edge, the unit SHALL enter IDLE and clear:
- o_busy, o_done, o_rd_wren;
- o_rd_addr, o_rd_data;
- the counter and all datapath registers.
REQ-028 Reset during CALC or DONE SHALL abort the operation with no write-back strobe.
REQ-029 Reset SHALL take priority over i_start on the same edge.

Structure
REQ-030 The div_op_e enum (2-bit) and the state enum SHALL live in the shared riscv_pkg.
REQ-031 The constants XLEN=32 and DIV_STEPS=32 SHALL also live in riscv_pkg.
REQ-032 div_unit SHALL be a single module with no sub-modules; the step logic is an internal combinational block.
REQ-033 The block SHALL be single clock domain and latch-free; all outputs SHALL be registered.

Verification
REQ-034 DIV 100/7, rd=5 -> o_done after 33 cycles, o_rd_data=14, o_rd_wren=1, o_rd_addr=5.
REQ-035 REM -7 % 2 (0xFFFFFFF9, 2) -> o_rd_data=0xFFFFFFFF; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
REQ-036 Special cases, each -> o_done after 1 cycle with the stated result:
- DIVU 5/0 -> 0xFFFFFFFF.
- REMU 5/0 -> 5.
- DIV 0x80000000/-1 -> 0x80000000.
- REM 0x80000000/-1 -> 0.
REQ-037 Reset asserted 10 cycles into CALC -> o_busy=0 on the next cycle, and no o_done for 40 cycles.
REQ-038 i_start re-pulsed with new operands mid-CALC -> result matches the first operands and exactly one o_done occurs.
REQ-039 DIV 9/3 with rd=0 -> o_done=1, o_rd_wren=0.
